// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between a CPU and a peripheral
//   requester (counter/LCD side). Grants are combinational in the request
//   cycle. The CPU has priority. A 4-bit starvation counter counts the cycles
//   the peripheral waits. When it reaches STARVE_MAX, the peripheral wins.
//   Read data is captured one edge after the grant and is flagged with a
//   one-cycle rvalid.
//
// Ports
//   clk, rst                           clock, async active-low reset
//   cpu_req/we/addr/wdata              CPU request and payload
//   cpu_gnt, cpu_rvalid, cpu_rdata     CPU grant and read return
//   per_*                              same set for the peripheral
//   mem_we/re/addr/wdata, mem_rdata    memory side (read data combinational)
//   owner                              registered last winner: 00/01/10
module data_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_PER  = 2'b10;

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [1:0]        owner_q, owner_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              per_rvalid_q, per_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] per_rdata_q, per_rdata_d;

  logic cpu_win;
  logic per_win;

  // Arbitration. rst gates the grants so that nothing reaches the memory
  // while reset is held. The first grant can come in the first cycle after
  // reset is released.
  always_comb begin
    per_win = 1'b0;
    cpu_win = 1'b0;
    if (rst) begin
      per_win = per_req && (!cpu_req || (wait_cnt_q == STARVE_LIM));
      cpu_win = cpu_req && !per_win;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (per_win) begin
      mem_we    = per_we;
      mem_re    = !per_we;
      mem_addr  = per_addr;
      mem_wdata = per_wdata;
    end else if (cpu_win) begin
      mem_we    = cpu_we;
      mem_re    = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    wait_cnt_d   = '0;
    owner_d      = OWN_NONE;
    cpu_rvalid_d = cpu_win && !cpu_we;
    per_rvalid_d = per_win && !per_we;
    cpu_rdata_d  = cpu_rdata_q;
    per_rdata_d  = per_rdata_q;

    // The counter only runs while the peripheral is asking and losing.
    if (per_req && !per_win) begin
      if (wait_cnt_q == STARVE_LIM) wait_cnt_d = wait_cnt_q;
      else                          wait_cnt_d = wait_cnt_q + 4'd1;
    end

    if (per_win)      owner_d = OWN_PER;
    else if (cpu_win) owner_d = OWN_CPU;

    if (cpu_rvalid_d) cpu_rdata_d = mem_rdata;
    if (per_rvalid_d) per_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= '0;
      owner_q      <= OWN_NONE;
      cpu_rvalid_q <= 1'b0;
      per_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      per_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      per_rvalid_q <= per_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      per_rdata_q  <= per_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_win;
  assign per_gnt    = per_win;
  assign cpu_rvalid = cpu_rvalid_q;
  assign per_rvalid = per_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign per_rdata  = per_rdata_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              per_req, per_we;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_gnt, per_rvalid;
  logic [DATA_W-1:0] per_rdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FE; cpu_wdata = '0;
    per_req = 1'b1; per_we = 1'b1; per_addr = 10'h001; per_wdata = 32'h5;
    mem_rdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); end
    checks++; if (per_gnt !== 1'b0) begin failures++; $display("FAIL reset_per_gnt got=%b exp=0", per_gnt); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_we, mem_re}); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
    checks++; if ({cpu_rvalid, per_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {cpu_rvalid, per_rvalid}); end
    checks++; if (cpu_rdata !== 32'h0 || per_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", cpu_rdata, per_rdata); end
    checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL reset_wait got=%0d exp=0", dut.wait_cnt_q); end
    cpu_req = 1'b0; per_req = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FE; mem_rdata = 32'h12345678;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || per_gnt !== 1'b0) begin failures++; $display("FAIL cpu_read_gnt got=%b%b exp=10", cpu_gnt, per_gnt); end
    checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL cpu_read_strobe got re=%b we=%b exp re=1 we=0", mem_re, mem_we); end
    checks++; if (mem_addr !== 10'h3FE) begin failures++; $display("FAIL cpu_read_addr got=%h exp=3fe", mem_addr); end
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL cpu_read_early_rvalid got=%b exp=0", cpu_rvalid); end
    @(posedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b1) begin failures++; $display("FAIL cpu_read_rvalid got=%b exp=1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h12345678) begin failures++; $display("FAIL cpu_read_rdata got=%h exp=12345678", cpu_rdata); end
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL cpu_read_owner got=%b exp=01", owner); end
    @(negedge clk);
    cpu_req = 1'b0; mem_rdata = 32'hAAAA5555;
    @(posedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL cpu_read_rvalid_one_cycle got=%b exp=0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h12345678) begin failures++; $display("FAIL cpu_read_rdata_hold got=%h exp=12345678", cpu_rdata); end
  endtask

  task automatic test_per_write();
    @(negedge clk);
    per_req = 1'b1; per_we = 1'b1; per_addr = 10'h3FB; per_wdata = 32'h1;
    #1;
    checks++; if (per_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL per_write_gnt got=%b%b exp=01", cpu_gnt, per_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin failures++; $display("FAIL per_write_strobe got we=%b re=%b exp we=1 re=0", mem_we, mem_re); end
    checks++; if (mem_addr !== 10'h3FB || mem_wdata !== 32'h1) begin failures++; $display("FAIL per_write_bus got=%h/%h exp=3fb/1", mem_addr, mem_wdata); end
    @(posedge clk); #1;
    checks++; if (per_rvalid !== 1'b0) begin failures++; $display("FAIL per_write_rvalid got=%b exp=0", per_rvalid); end
    checks++; if (per_rdata !== 32'h0) begin failures++; $display("FAIL per_write_rdata_hold got=%h exp=0", per_rdata); end
    checks++; if (owner !== 2'b10) begin failures++; $display("FAIL per_write_owner got=%b exp=10", owner); end
    per_we = 1'b0;
  endtask

  task automatic test_idle();
    @(negedge clk);
    cpu_req = 1'b0; per_req = 1'b0;
    cpu_addr = 10'h155; cpu_wdata = 32'hFFFF0000; per_addr = 10'h2AA; per_wdata = 32'h0000FFFF;
    #1;
    checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL idle_strobes got=%b exp=00", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL idle_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1;
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL idle_owner got=%b exp=00", owner); end
  endtask

  task automatic test_starvation();
    logic exp_per;
    logic [3:0] exp_wait;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    per_req = 1'b1; per_we = 1'b0; per_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_rdata = 32'h100 + i;
      exp_per  = ((i % 5) == 4);
      exp_wait = exp_per ? 4'd0 : 4'((i % 5) + 1);
      #1;
      checks++; if (cpu_gnt !== !exp_per || per_gnt !== exp_per) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%b%b exp=%b%b", i, cpu_gnt, per_gnt, !exp_per, exp_per); end
      checks++; if (mem_addr !== (exp_per ? 10'h020 : 10'h010)) begin failures++; $display("FAIL starve_addr cyc=%0d got=%h", i, mem_addr); end
      @(posedge clk); #1;
      checks++; if (dut.wait_cnt_q !== exp_wait) begin failures++; $display("FAIL starve_wait cyc=%0d got=%0d exp=%0d", i, dut.wait_cnt_q, exp_wait); end
      checks++; if (per_rvalid !== exp_per || cpu_rvalid !== !exp_per) begin failures++; $display("FAIL starve_rvalid cyc=%0d got=%b%b exp=%b%b", i, cpu_rvalid, per_rvalid, !exp_per, exp_per); end
      if (exp_per) begin
        checks++; if (per_rdata !== 32'h100 + i) begin failures++; $display("FAIL starve_per_rdata cyc=%0d got=%h exp=%h", i, per_rdata, 32'h100 + i); end
      end else begin
        checks++; if (cpu_rdata !== 32'h100 + i) begin failures++; $display("FAIL starve_cpu_rdata cyc=%0d got=%h exp=%h", i, cpu_rdata, 32'h100 + i); end
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; per_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'(32 + i); cpu_wdata = 32'hA0 + i;
      #1;
      checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'(32 + i)) begin failures++; $display("FAIL b2b_write cyc=%0d got gnt=%b we=%b addr=%h", i, cpu_gnt, mem_we, mem_addr); end
      @(posedge clk); #1;
      checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_write_rvalid cyc=%0d got=%b exp=0", i, cpu_rvalid); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 10'(32 + i); mem_rdata = 32'hB0 + i;
      #1;
      checks++; if (cpu_gnt !== 1'b1 || mem_re !== 1'b1) begin failures++; $display("FAIL b2b_read_gnt cyc=%0d got gnt=%b re=%b", i, cpu_gnt, mem_re); end
      @(posedge clk); #1;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB0 + i) begin failures++; $display("FAIL b2b_read cyc=%0d got rvalid=%b rdata=%h exp=1/%h", i, cpu_rvalid, cpu_rdata, 32'hB0 + i); end
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic test_per_restart();
    @(negedge clk);
    per_req = 1'b1; per_we = 1'b0; per_addr = 10'h030; mem_rdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (per_gnt !== 1'b1) begin failures++; $display("FAIL restart_alone_gnt cyc=%0d got=%b exp=1", i, per_gnt); end
      @(posedge clk); #1;
      checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL restart_alone_wait cyc=%0d got=%0d exp=0", i, dut.wait_cnt_q); end
    end
    @(negedge clk);
    per_req = 1'b0;
    @(negedge clk);
    per_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h040;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || per_gnt !== 1'b0) begin failures++; $display("FAIL restart_cpu_wins got=%b%b exp=10", cpu_gnt, per_gnt); end
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt_q !== 4'd1) begin failures++; $display("FAIL restart_wait1 got=%0d exp=1", dut.wait_cnt_q); end
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt_q !== 4'd2) begin failures++; $display("FAIL restart_wait2 got=%0d exp=2", dut.wait_cnt_q); end
    @(negedge clk);
    per_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL restart_wait_drop got=%0d exp=0", dut.wait_cnt_q); end
    @(negedge clk);
    per_req = 1'b1;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || per_gnt !== 1'b0) begin failures++; $display("FAIL restart_cpu_wins2 got=%b%b exp=10", cpu_gnt, per_gnt); end
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt_q !== 4'd1) begin failures++; $display("FAIL restart_wait_again got=%0d exp=1", dut.wait_cnt_q); end
    @(negedge clk);
    cpu_req = 1'b0; per_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
    per_req = 1'b1; per_we = 1'b0; per_addr = 10'h022; mem_rdata = 32'h99;
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt_q !== 4'd1) begin failures++; $display("FAIL midrst_pre_wait got=%0d exp=1", dut.wait_cnt_q); end
    @(negedge clk); #1;
    checks++; if (cpu_gnt !== 1'b1 || mem_re !== 1'b1) begin failures++; $display("FAIL midrst_pre_gnt got gnt=%b re=%b exp=1/1", cpu_gnt, mem_re); end
    #2 rst = 1'b0;
    #1;
    checks++; if (cpu_gnt !== 1'b0 || per_gnt !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL midrst_gnt got=%b%b re=%b exp=00 0", cpu_gnt, per_gnt, mem_re); end
    checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL midrst_wait got=%0d exp=0", dut.wait_cnt_q); end
    @(posedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h0 || owner !== 2'b00) begin failures++; $display("FAIL midrst_regs got rdata=%h owner=%b exp=0/00", cpu_rdata, owner); end
    @(negedge clk);
    rst = 1'b1; per_req = 1'b0; cpu_addr = 10'h055; mem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL midrst_first_gnt got=%b exp=1", cpu_gnt); end
    @(posedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL midrst_after_read got=%b/%h exp=1/cafef00d", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_per_write();
    test_idle();
    test_starvation();
    test_back_to_back();
    test_per_restart();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
